// File: rtl/pwm_multi_channel.sv
// N-channel PWM (off/static/breathe/blink) on one shared period counter; pwm_out lags the counter by one cycle.
// Duty reloads only at period boundaries; cfg_ready is held high after reset, so there is no backpressure.
module pwm_multi_channel #(
    parameter int CHANNELS     = 2,
    parameter int WIDTH        = 10,
    parameter int STEP_PERIODS = 64,
    parameter int ON_PERIODS   = 256,
    parameter int OFF_PERIODS  = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    input  logic [3:0]          cfg_channel,
    input  logic [1:0]          cfg_mode,
    input  logic [WIDTH-1:0]    cfg_level,
    output logic                cfg_ready,
    output logic                cfg_error,
    output logic                period_start,
    output logic [CHANNELS-1:0] pwm_out
);
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_t;

    localparam int MAXP_SO = (STEP_PERIODS > ON_PERIODS) ? STEP_PERIODS : ON_PERIODS;
    localparam int MAXP    = (MAXP_SO > OFF_PERIODS) ? MAXP_SO : OFF_PERIODS;
    localparam int SUB_W   = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [SUB_W-1:0] STEP_LAST = SUB_W'(STEP_PERIODS - 1);
    localparam logic [SUB_W-1:0] ON_LAST   = SUB_W'(ON_PERIODS - 1);
    localparam logic [SUB_W-1:0] OFF_LAST  = SUB_W'(OFF_PERIODS - 1);
    localparam logic [SUB_W-1:0] SUB_ONE   = SUB_W'(1);
    localparam logic [WIDTH-1:0] W_ONE     = WIDTH'(1);
    localparam logic [4:0]       CH_LIM    = 5'(CHANNELS);

    logic [WIDTH-1:0] cnt;
    logic             boundary;
    logic             cfg_fire;

    assign boundary = (cnt == '0);
    assign cfg_fire = cfg_valid && cfg_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            period_start <= 1'b0;
            cfg_ready    <= 1'b0;
            cfg_error    <= 1'b0;
        end else begin
            cnt          <= cnt + W_ONE;
            period_start <= boundary;
            cfg_ready    <= 1'b1;
            cfg_error    <= cfg_fire && ({1'b0, cfg_channel} >= CH_LIM);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [3:0] IDX = 4'(i);

        mode_t            mode_q;
        logic [WIDTH-1:0] level_q;
        logic [WIDTH-1:0] ramp_q;
        logic             dir_down_q;
        logic             blink_on_q;
        logic [SUB_W-1:0] sub_q;
        logic [WIDTH-1:0] duty_q;
        logic             pwm_q;

        logic [WIDTH-1:0] duty_src;
        logic [WIDTH-1:0] duty_eff;
        logic [WIDTH-1:0] ramp_adv;
        logic             dir_adv;
        logic             blink_adv;
        logic [SUB_W-1:0] sub_adv;
        logic             wr_hit;
        mode_t            wr_mode;

        assign wr_hit  = cfg_fire && (cfg_channel == IDX);
        assign wr_mode = mode_t'(cfg_mode);
        // At the boundary the freshly sampled duty is compared directly so cnt==0 already uses it.
        assign duty_eff = boundary ? duty_src : duty_q;
        assign pwm_out[i] = pwm_q;

        always_comb begin
            duty_src  = '0;
            ramp_adv  = ramp_q;
            dir_adv   = dir_down_q;
            blink_adv = blink_on_q;
            sub_adv   = sub_q;
            case (mode_q)
                MODE_STATIC: duty_src = level_q;
                MODE_BREATHE: begin
                    duty_src = ramp_q;
                    if (sub_q == STEP_LAST) begin
                        sub_adv = '0;
                        if (level_q == '0) begin
                            ramp_adv = '0;
                            dir_adv  = 1'b0;
                        end else if (!dir_down_q) begin
                            if (ramp_q == level_q) begin
                                dir_adv  = 1'b1;
                                ramp_adv = ramp_q - W_ONE;
                            end else begin
                                ramp_adv = ramp_q + W_ONE;
                            end
                        end else begin
                            if (ramp_q == '0) begin
                                dir_adv  = 1'b0;
                                ramp_adv = ramp_q + W_ONE;
                            end else begin
                                ramp_adv = ramp_q - W_ONE;
                            end
                        end
                    end else begin
                        sub_adv = sub_q + SUB_ONE;
                    end
                end
                MODE_BLINK: begin
                    duty_src = blink_on_q ? level_q : '0;
                    if (blink_on_q) begin
                        if (sub_q == ON_LAST) begin
                            sub_adv   = '0;
                            blink_adv = 1'b0;
                        end else begin
                            sub_adv = sub_q + SUB_ONE;
                        end
                    end else begin
                        if (sub_q == OFF_LAST) begin
                            sub_adv   = '0;
                            blink_adv = 1'b1;
                        end else begin
                            sub_adv = sub_q + SUB_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mode_q     <= MODE_OFF;
                level_q    <= '0;
                ramp_q     <= '0;
                dir_down_q <= 1'b0;
                blink_on_q <= 1'b0;
                sub_q      <= '0;
                duty_q     <= '0;
                pwm_q      <= 1'b0;
            end else begin
                // A write landing on a boundary wins over that boundary's phase advance.
                if (wr_hit) begin
                    mode_q  <= wr_mode;
                    level_q <= cfg_level;
                    if (wr_mode != mode_q) begin
                        ramp_q     <= '0;
                        dir_down_q <= 1'b0;
                        blink_on_q <= 1'b1;
                        sub_q      <= '0;
                    end else if (mode_q == MODE_BREATHE && ramp_q > cfg_level) begin
                        ramp_q     <= cfg_level;
                        dir_down_q <= 1'b1;
                    end
                end else if (boundary) begin
                    ramp_q     <= ramp_adv;
                    dir_down_q <= dir_adv;
                    blink_on_q <= blink_adv;
                    sub_q      <= sub_adv;
                end
                if (boundary) begin
                    duty_q <= duty_src;
                end
                pwm_q <= (cnt < duty_eff);
            end
        end
    end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
- N-channel PWM generator that replaces the single LED breathing counter and the separate LED/buzzer pwm instances in the clock top level.
- One shared period counter drives all channels.
- Each channel runs an independent mode (off, static, breathe, blink) with glitch-free duty updates at period boundaries.
- Configured by the control block over a valid/ready port: one channel write per transfer.

Parameters:
- CHANNELS, 2, number of PWM outputs (1..16).
- WIDTH, 10, duty/counter width; the PWM period is 2^WIDTH clk cycles.
- STEP_PERIODS, 64, PWM periods per breathe ramp step (>=1).
- ON_PERIODS, 256, PWM periods in the blink on-phase (>=1).
- OFF_PERIODS, 256, PWM periods in the blink off-phase (>=1).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- cfg_valid, input, 1, configuration write request.
- cfg_channel, input, 4, target channel index.
- cfg_mode, input, 2, mode: 0 OFF, 1 STATIC, 2 BREATHE, 3 BLINK.
- cfg_level, input, WIDTH, duty level (static/blink duty, breathe peak).
- cfg_ready, output, 1, write accepted when cfg_valid && cfg_ready.
- cfg_error, output, 1, one-cycle pulse on a write to a channel >= CHANNELS.
- period_start, output, 1, one-cycle pulse when the period counter is 0.
- pwm_out, output, CHANNELS, PWM outputs.

Behaviour:
- Reset, asynchronous and active-low, with all registers cleared while reset is low:
  - pwm_out=0, cfg_ready=0, cfg_error=0, period_start=0.
  - Every channel: mode OFF, level 0, duty 0.
- cfg_ready goes 1 on the first clk edge after reset deasserts and stays 1; there is no backpressure.
- Period counter:
  - WIDTH bits, increments every clk, wraps 2^WIDTH-1 -> 0.
  - period_start is registered: it is high the cycle after the counter equals 0.
- Per channel, pwm_out[i] is registered: it equals (cnt < duty_active[i]) from the previous cycle.
  - duty 0 gives constant low.
  - duty 2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH cycles.
- Config write (cfg_valid && cfg_ready at edge t):
  - Mode and level registers update at t+1.
  - duty_active is reloaded only when cnt==0, so there are never partial periods.
  - A changed mode resets the channel phase: breathe ramp=0 direction up; blink on-phase; period sub-counter=0.
  - Same mode with a new level keeps the phase. In BREATHE, if ramp > new level, ramp is clamped to the level and the direction is set down.
  - If cfg_channel >= CHANNELS: no state change, and cfg_error is high during cycle t+1.
- Per-channel duty source, sampled at each period boundary:
  - OFF: 0.
  - STATIC: level.
  - BREATHE: triangle wave.
    - Every STEP_PERIODS boundaries the ramp steps by 1.
    - Going up: ramp==level flips the direction to down and decrements.
    - Going down: ramp==0 flips the direction to up and increments.
    - So with level L the sequence is 0,1..L,L-1..0,1... with no endpoint hold.
    - level 0 keeps the ramp at 0.
  - BLINK: level for ON_PERIODS periods, then 0 for OFF_PERIODS periods, repeating.
- Sub-counters:
  - The per-channel period sub-counter counts period boundaries.
  - Its width is the clog2 of max(STEP_PERIODS, ON_PERIODS, OFF_PERIODS).
  - It never overflows: it clears on phase or step completion.
- Simultaneous config write and cnt==0 boundary: the boundary uses the old registers; the new values apply at the next boundary.
- Channels are fully independent; writing one channel never disturbs the phase of another.
- Reset asserted mid-period: pwm_out drops to 0 asynchronously; after release, the counter restarts from 0.

Test Plan (WIDTH=4, CHANNELS=2, STEP_PERIODS=1, ON_PERIODS=2, OFF_PERIODS=1):
- Reset, then idle -> pwm_out=00, cfg_ready=0 during reset and 1 on the first edge after release; period_start pulses every 16 cycles.
- Write ch0 STATIC level 4 -> from the next boundary, pwm_out[0] is high 4 cycles and low 12 per period; pwm_out[1] stays 0.
- Write ch0 STATIC level 12 at cnt=8 of a level-4 period -> the current period keeps the 4-cycle high time; the next period is high for 12 cycles.
- Write ch1 BREATHE level 3 -> per-period high times 0,1,2,3,2,1,0,1,2...
  - Then rewrite level 1 while the ramp is 3 -> next high times 1,0,1,0...
- Write ch0 BLINK level 15 -> per-period high times 15,15,0,15,15,0.
  - Then write mode OFF -> 0 from the next boundary.
- Write channel 5 -> cfg_error=1 for exactly one cycle, no output change.
  - Then assert reset at cnt=7 with ch0 STATIC 12 -> pwm_out=00 immediately.
  - After release, all channels are OFF.
